// File: rtl/sync_pkg.sv
// Shared state encoding for the synchronization sequencer.
// Width-independent items only; sizing parameters live on the modules.
package sync_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE          = 4'd0,
    FG_WAIT       = 4'd1,
    FG            = 4'd2,
    DETONATE      = 4'd3,
    WIRE_WAIT     = 4'd4,
    DETECTOR_BUSY = 4'd5,
    DETECTOR_WAIT = 4'd6,
    FINISHED      = 4'd7,
    ERROR         = 4'd8
  } state_e;

endpackage

// File: rtl/det_pulse_channel.sv
// One detonation channel: a PULSE_W-cycle pulse starting `delay`
// cycles after the start edge.
module det_pulse_channel #(
  parameter int CNT_W   = 32,
  parameter int PULSE_W = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic [CNT_W-1:0] delay,
  input  logic             abort,
  output logic             pulse,
  output logic             busy
);

  localparam logic [CNT_W:0] ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] TAIL = (CNT_W+1)'(PULSE_W - 1);

  logic           active;
  logic [CNT_W:0] cnt;
  logic [CNT_W:0] nxt;
  logic [CNT_W:0] last;

  // cnt is the index of the current DETONATE cycle
  assign nxt  = cnt + ONE;
  assign last = {1'b0, delay} + TAIL;
  assign busy = active && (cnt != last);

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      active <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else if (start) begin
      active <= enable;
      cnt    <= '0;
      pulse  <= enable && (delay == '0);
    end else if (active) begin
      active <= busy;
      cnt    <= nxt;
      pulse  <= busy && (nxt >= {1'b0, delay});
    end
  end

endmodule

// File: rtl/sync_sequencer.sv
// Experiment sequencer: FG sync, delayed multi-channel detonation,
// wire-break detector trigger with timeouts, abort and status.
module sync_sequencer
  import sync_pkg::*;
#(
  parameter int N_CH             = 4,
  parameter int CNT_W            = 32,
  parameter int FG_DELAY         = 400_000,
  parameter int PULSE_W          = 50,
  parameter int WIRE_TIMEOUT     = 350_000,
  parameter int DETECTOR_TIMEOUT = 500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_signal,
  input  logic                  fg_signal,
  input  logic                  wire_signal,
  input  logic                  detector_ready,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      phase_shift,
  input  logic [N_CH*CNT_W-1:0] ch_delay,
  input  logic [N_CH-1:0]       ch_enable,
  output logic [N_CH-1:0]       detonation_signal,
  output logic                  output_trigger,
  output logic [STATE_W-1:0]    scenario_state,
  output logic [CNT_W-1:0]      counter_,
  output logic                  wire_timeout,
  output logic                  detector_timeout,
  output logic                  done
);

  localparam logic [CNT_W:0] ONE      = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] FG_BASE  = (CNT_W+1)'(FG_DELAY);
  localparam logic [CNT_W:0] WIRE_END = (CNT_W+1)'(WIRE_TIMEOUT - 1);
  localparam logic [CNT_W:0] DET_END  = (CNT_W+1)'(DETECTOR_TIMEOUT - 1);

  state_e                state;
  logic [CNT_W:0]        cnt;
  logic [CNT_W:0]        target;
  logic [N_CH-1:0]       en_q;
  logic [N_CH*CNT_W-1:0] dly_q;
  logic [N_CH-1:0]       busy;
  logic                  fg_done;
  logic                  kill;

  // extra counter bit keeps FG_DELAY + phase_shift from wrapping
  assign fg_done = (state == FG) && (cnt == target);
  assign kill    = abort && (state != IDLE);

  assign scenario_state = state;
  assign counter_       = cnt[CNT_W-1:0];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    det_pulse_channel #(
      .CNT_W  (CNT_W),
      .PULSE_W(PULSE_W)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .start (fg_done),
      .enable(en_q[i]),
      .delay (dly_q[i*CNT_W +: CNT_W]),
      .abort (kill),
      .pulse (detonation_signal[i]),
      .busy  (busy[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      target           <= '0;
      en_q             <= '0;
      dly_q            <= '0;
      output_trigger   <= 1'b0;
      wire_timeout     <= 1'b0;
      detector_timeout <= 1'b0;
      done             <= 1'b0;
    end else if (kill) begin
      state          <= IDLE;
      cnt            <= '0;
      output_trigger <= 1'b0;
      done           <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_signal) begin
            state            <= FG_WAIT;
            wire_timeout     <= 1'b0;
            detector_timeout <= 1'b0;
          end
        end
        FG_WAIT: begin
          if (fg_signal) begin
            state  <= FG;
            cnt    <= '0;
            en_q   <= ch_enable;
            dly_q  <= ch_delay;
            target <= FG_BASE + {1'b0, phase_shift};
          end
        end
        FG: begin
          if (fg_done) begin
            state <= DETONATE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DETONATE: begin
          if (!(|busy)) begin
            state <= WIRE_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        WIRE_WAIT: begin
          if (wire_signal) begin
            state          <= DETECTOR_BUSY;
            output_trigger <= 1'b1;
            cnt            <= '0;
          end else if (cnt == WIRE_END) begin
            state        <= ERROR;
            wire_timeout <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DETECTOR_BUSY: begin
          if (!detector_ready) begin
            state <= DETECTOR_WAIT;
            cnt   <= '0;
          end
        end
        DETECTOR_WAIT: begin
          if (detector_ready || cnt == DET_END) begin
            state          <= FINISHED;
            output_trigger <= 1'b0;
            cnt            <= '0;
            done           <= 1'b1;
            if (!detector_ready) detector_timeout <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        FINISHED, ERROR: begin
          if (!start_signal) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          cnt            <= '0;
          output_trigger <= 1'b0;
          done           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_sequencer.sv
// Scoreboard bench: expected output events are queued per run and
// matched against changes seen on the DUT outputs.
module tb_sync_sequencer;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam int FGD   = 100;
  localparam int PW    = 5;
  localparam int WTO   = 50;
  localparam int DTO   = 20;

  localparam int K_ST = 1;
  localparam int K_DT = 2;
  localparam int K_TR = 3;
  localparam int K_DN = 4;
  localparam int K_WT = 5;
  localparam int K_DE = 6;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  start_signal = 1'b0;
  logic                  fg_signal = 1'b0;
  logic                  wire_signal = 1'b1;
  logic                  detector_ready = 1'b0;
  logic                  abort = 1'b0;
  logic [CNT_W-1:0]      phase_shift = '0;
  logic [N_CH*CNT_W-1:0] ch_delay = {32'd30, 32'd20, 32'd10, 32'd0};
  logic [N_CH-1:0]       ch_enable = '0;
  logic [N_CH-1:0]       detonation_signal;
  logic                  output_trigger;
  logic [3:0]            scenario_state;
  logic [CNT_W-1:0]      counter_;
  logic                  wire_timeout;
  logic                  detector_timeout;
  logic                  done;

  sync_sequencer #(
    .N_CH            (N_CH),
    .CNT_W           (CNT_W),
    .FG_DELAY        (FGD),
    .PULSE_W         (PW),
    .WIRE_TIMEOUT    (WTO),
    .DETECTOR_TIMEOUT(DTO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start_signal     (start_signal),
    .fg_signal        (fg_signal),
    .wire_signal      (wire_signal),
    .detector_ready   (detector_ready),
    .abort            (abort),
    .phase_shift      (phase_shift),
    .ch_delay         (ch_delay),
    .ch_enable        (ch_enable),
    .detonation_signal(detonation_signal),
    .output_trigger   (output_trigger),
    .scenario_state   (scenario_state),
    .counter_         (counter_),
    .wire_timeout     (wire_timeout),
    .detector_timeout (detector_timeout),
    .done             (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int c0 = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  logic [63:0] expq[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ev(int k, int idx, logic [15:0] v, int rel);
    return {8'(k), 8'(idx), v, 32'(rel)};
  endfunction

  task automatic push(int k, int idx, int v, int rel);
    expq.push_back(ev(k, idx, 16'(v), rel));
  endtask

  task automatic observe(int k, int idx, logic [15:0] v);
    logic [63:0] a;
    a = ev(k, idx, v, cyc - c0);
    if (expq.size() == 0) check("unexpected event", a, 64'd0);
    else check("event", a, expq.pop_front());
  endtask

  logic [3:0]      p_st = '0;
  logic [N_CH-1:0] p_dt = '0;
  logic            p_tr = 1'b0;
  logic            p_dn = 1'b0;
  logic            p_wt = 1'b0;
  logic            p_de = 1'b0;

  // fixed order per edge: state, channels, trigger, done, flags
  always @(negedge clock) begin
    if (mon_en) begin
      if (scenario_state !== p_st) observe(K_ST, 0, 16'(scenario_state));
      for (int i = 0; i < N_CH; i++)
        if (detonation_signal[i] !== p_dt[i])
          observe(K_DT, i, 16'(detonation_signal[i]));
      if (output_trigger !== p_tr) observe(K_TR, 0, 16'(output_trigger));
      if (done !== p_dn) observe(K_DN, 0, 16'(done));
      if (wire_timeout !== p_wt) observe(K_WT, 0, 16'(wire_timeout));
      if (detector_timeout !== p_de) observe(K_DE, 0, 16'(detector_timeout));
      p_st <= scenario_state;
      p_dt <= detonation_signal;
      p_tr <= output_trigger;
      p_dn <= done;
      p_wt <= wire_timeout;
      p_de <= detector_timeout;
    end
  end

  task automatic at(int rel);
    while (cyc < c0 + rel) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic begin_run(logic [N_CH-1:0] en, logic [CNT_W-1:0] ps);
    @(posedge clock);
    #1;
    c0 = cyc;
    ch_enable = en;
    phase_shift = ps;
    start_signal = 1'b1;
    fg_signal = 1'b1;
  endtask

  task automatic end_run(int rel);
    at(rel);
    check("pending events", 64'(expq.size()), 64'd0);
    expq.delete();
    fg_signal = 1'b0;
  endtask

  int d;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst state", 64'(scenario_state), 64'd0);
    check("rst det", 64'(detonation_signal), 64'd0);
    check("rst trig", 64'(output_trigger), 64'd0);
    check("rst cnt", 64'(counter_), 64'd0);
    check("rst flags", 64'({wire_timeout, detector_timeout}), 64'd0);
    check("rst done", 64'(done), 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // nominal run, all channels, phase shift 7
    begin_run(4'b1111, 32'd7);
    d = 3 + FGD + 7;
    push(K_ST, 0, 1, 1);
    push(K_ST, 0, 2, 2);
    push(K_ST, 0, 3, d);
    push(K_DT, 0, 1, d);
    push(K_DT, 0, 0, d + 5);
    push(K_DT, 1, 1, d + 10);
    push(K_DT, 1, 0, d + 15);
    push(K_DT, 2, 1, d + 20);
    push(K_DT, 2, 0, d + 25);
    push(K_DT, 3, 1, d + 30);
    push(K_ST, 0, 4, d + 35);
    push(K_DT, 3, 0, d + 35);
    push(K_ST, 0, 5, d + 36);
    push(K_TR, 0, 1, d + 36);
    push(K_ST, 0, 6, d + 37);
    push(K_ST, 0, 7, d + 41);
    push(K_TR, 0, 0, d + 41);
    push(K_DN, 0, 1, d + 41);
    push(K_ST, 0, 0, d + 46);
    push(K_DN, 0, 0, d + 46);
    at(d + 38);
    check("wait cnt", 64'(counter_), 64'd1);
    check("wait trig", 64'(output_trigger), 64'd1);
    at(d + 40);
    detector_ready = 1'b1;
    at(d + 45);
    start_signal = 1'b0;
    end_run(d + 50);
    detector_ready = 1'b0;

    // channels 0 and 2 only, detector timeout
    begin_run(4'b0101, 32'd0);
    d = 3 + FGD;
    push(K_ST, 0, 1, 1);
    push(K_ST, 0, 2, 2);
    push(K_ST, 0, 3, d);
    push(K_DT, 0, 1, d);
    push(K_DT, 0, 0, d + 5);
    push(K_DT, 2, 1, d + 20);
    push(K_ST, 0, 4, d + 25);
    push(K_DT, 2, 0, d + 25);
    push(K_ST, 0, 5, d + 26);
    push(K_TR, 0, 1, d + 26);
    push(K_ST, 0, 6, d + 27);
    push(K_ST, 0, 7, d + 27 + DTO);
    push(K_TR, 0, 0, d + 27 + DTO);
    push(K_DN, 0, 1, d + 27 + DTO);
    push(K_DE, 0, 1, d + 27 + DTO);
    push(K_ST, 0, 0, d + 51);
    push(K_DN, 0, 0, d + 51);
    at(d + 50);
    start_signal = 1'b0;
    end_run(d + 55);
    check("det timeout flag", 64'(detector_timeout), 64'd1);

    // no wire break: wire timeout into ERROR
    wire_signal = 1'b0;
    begin_run(4'b0000, 32'd0);
    d = 3 + FGD;
    push(K_ST, 0, 1, 1);
    push(K_DE, 0, 0, 1);
    push(K_ST, 0, 2, 2);
    push(K_ST, 0, 3, d);
    push(K_ST, 0, 4, d + 1);
    push(K_ST, 0, 8, d + 1 + WTO);
    push(K_WT, 0, 1, d + 1 + WTO);
    push(K_ST, 0, 0, d + 56);
    at(d + 30);
    check("wire cnt", 64'(counter_), 64'd29);
    at(d + 53);
    check("error trig", 64'(output_trigger), 64'd0);
    check("error done", 64'(done), 64'd0);
    at(d + 55);
    start_signal = 1'b0;
    end_run(d + 60);
    check("wire timeout flag", 64'(wire_timeout), 64'd1);
    wire_signal = 1'b1;

    // abort during channel 1 pulse
    begin_run(4'b1111, 32'd0);
    d = 3 + FGD;
    push(K_ST, 0, 1, 1);
    push(K_WT, 0, 0, 1);
    push(K_ST, 0, 2, 2);
    push(K_ST, 0, 3, d);
    push(K_DT, 0, 1, d);
    push(K_DT, 0, 0, d + 5);
    push(K_DT, 1, 1, d + 10);
    push(K_ST, 0, 0, d + 12);
    push(K_DT, 1, 0, d + 12);
    at(d + 11);
    abort = 1'b1;
    at(d + 12);
    check("abort det", 64'(detonation_signal), 64'd0);
    check("abort cnt", 64'(counter_), 64'd0);
    abort = 1'b0;
    start_signal = 1'b0;
    end_run(d + 20);

    // reset in FG with a phase shift that would wrap in CNT_W bits
    begin_run(4'b1111, 32'hFFFF_FFFF);
    push(K_ST, 0, 1, 1);
    push(K_ST, 0, 2, 2);
    push(K_ST, 0, 0, 111);
    at(110);
    check("no wrap state", 64'(scenario_state), 64'd2);
    check("no wrap cnt", 64'(counter_), 64'd108);
    reset = 1'b1;
    start_signal = 1'b0;
    at(111);
    reset = 1'b0;
    check("fg rst cnt", 64'(counter_), 64'd0);
    end_run(115);

    // reset in DETONATE mid-pulse
    begin_run(4'b0001, 32'd0);
    d = 3 + FGD;
    push(K_ST, 0, 1, 1);
    push(K_ST, 0, 2, 2);
    push(K_ST, 0, 3, d);
    push(K_DT, 0, 1, d);
    push(K_ST, 0, 0, d + 3);
    push(K_DT, 0, 0, d + 3);
    at(d + 2);
    reset = 1'b1;
    start_signal = 1'b0;
    at(d + 3);
    reset = 1'b0;
    check("det rst outs",
          64'({detonation_signal, output_trigger, done,
               wire_timeout, detector_timeout}), 64'd0);
    check("det rst cnt", 64'(counter_), 64'd0);
    end_run(d + 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
